// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, sequencer states
// and the alignment check used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } lsu_state_t;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (norm_size(size))
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: extracts/extends load lanes and merges subword
// store data into a previously read word. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        // Half accesses only look at offset[1]; offset[0] is dropped.
        half_sel = offset[1] ? word[15:0] : word[31:16];

        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: store_word[31:24] = wdata[7:0];
                    2'd1: store_word[23:16] = wdata[7:0];
                    2'd2: store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) store_word[15:0]  = wdata[15:0];
                else           store_word[31:16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for a big-endian word memory; subword stores use a
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_data_rw,
    output logic              mem_ena_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [2:0]        state
);

    // Handshake: a request is taken on a rising edge where req=1 and ready=1;
    // the caller holds its request until then, and done pulses for one cycle
    // when the access has completed (rdata/err valid in that cycle).

    lsu_state_t  state_q;
    logic        ready_q, done_q, ena_q, rw_q;
    logic [1:0]  size_q, off_q;
    logic        sext_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data, store_word;
    logic [1:0]  req_size;

    assign req_size = norm_size(size);

    lsu_lane_align u_align (
        .word       (mem_data_out),
        .old_word   (mem_data_out),
        .wdata      (wdata_q),
        .offset     (off_q),
        .size       (size_q),
        .sign_ext   (sext_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    logic trap;
    assign trap = is_misaligned(req_size, addr[1:0]);
    assign err  = err_q;
`else
    logic trap;
    assign trap = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ena_q       <= 1'b0;
            rw_q        <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        size_q   <= req_size;
                        off_q    <= addr[1:0];
                        sext_q   <= sign_ext;
                        wdata_q  <= wdata;
                        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                        ready_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        err_q    <= trap;
`endif
                        if (trap) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (!we) begin
                            ena_q   <= 1'b1;
                            state_q <= ST_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            mem_data_in <= wdata;
                            rw_q        <= 1'b1;
                            state_q     <= ST_WRITE;
                        end else begin
                            ena_q   <= 1'b1;
                            state_q <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata   <= load_data;
                    ena_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_RMW_RD: begin
                    // mem_data_in doubles as the merge register for the write.
                    mem_data_in <= store_word;
                    ena_q       <= 1'b0;
                    rw_q        <= 1'b1;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    rw_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ena_q   <= 1'b0;
                    rw_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready        = ready_q;
    assign busy         = ~ready_q;
    assign done         = done_q;
    // Gated so a reset landing in WRITE cannot commit a partial RMW.
    assign mem_data_rw  = rw_q & ~rst;
    assign mem_ena_data = ena_q & ~rst;
    assign state        = state_q;

endmodule
